// File: rtl/cia_pkg.sv
// cia_pkg: shared constants and types for the CIA serial port
package cia_pkg;
   localparam int   SDR_BITS = 8;
   localparam logic CNT_IDLE = 1'b1;
   localparam logic SP_IDLE  = 1'b1;
   typedef enum logic {S_IDLE, S_SHIFT} sdr_state_t;
endpackage

// File: rtl/cia_sync2.sv
// cia_sync2: two-flop enable-qualified synchronizer for an asynchronous pin
module cia_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);
   logic [1:0] r_ff;
   // Pins idle high, so reset to the idle level to avoid a spurious edge
   always_ff @(posedge clk)
      if (i_en) r_ff <= reset ? {2{RST_VAL}} : {r_ff[0], i_d};
   assign o_q = r_ff[1];
endmodule

// File: rtl/cia_serial.sv
// cia_serial: CIA 8520 serial data port, timer-A paced output and CNT clocked input
module cia_serial
   import cia_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clk7_en,
   input  logic       wr,
   input  logic       sdr,
   input  logic       spmode,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       tmra_ovf,
   input  logic       sp_in,
   input  logic       cnt_in,
   output logic       sp_out,
   output logic       cnt_out,
   output logic       irq
);
   logic       w_sp, w_cnt, w_wr, w_rise, w_mchg, w_last;
   logic       r_cnt_prev, r_mode, r_pending, r_cnt_out, r_sp_out, r_irq;
   logic       w_pending, w_cnt_out, w_sp_out, w_irq;
   logic [7:0] r_sdr, r_shift, w_sdr, w_shift;
   logic [3:0] r_bitcnt, w_bitcnt;
   sdr_state_t r_state, w_state;

   cia_sync2 u_sync_sp  (.clk(clk), .reset(reset), .i_en(clk7_en), .i_d(sp_in),  .o_q(w_sp));
   cia_sync2 u_sync_cnt (.clk(clk), .reset(reset), .i_en(clk7_en), .i_d(cnt_in), .o_q(w_cnt));

   assign w_wr     = wr & sdr;
   assign w_rise   = w_cnt & ~r_cnt_prev;
   assign w_mchg   = spmode ^ r_mode;
   assign w_last   = r_bitcnt == 4'(SDR_BITS - 1);
   assign data_out = (~wr & sdr) ? r_sdr : 8'h00;
   assign sp_out   = r_sp_out;
   assign cnt_out  = r_cnt_out;
   assign irq      = r_irq;

   // Next-state logic: abort on mode change, else input shifting or output sequencing
   always_comb begin
      w_state   = r_state;
      w_sdr     = w_wr ? data_in : r_sdr;
      w_shift   = r_shift;
      w_bitcnt  = r_bitcnt;
      w_pending = r_pending | (w_wr & spmode);
      w_cnt_out = r_cnt_out;
      w_sp_out  = r_sp_out;
      w_irq     = 1'b0;
      if (w_mchg) begin
         w_state   = S_IDLE;
         w_shift   = 8'h00;
         w_bitcnt  = 4'd0;
         w_pending = 1'b0;
         w_cnt_out = CNT_IDLE;
         w_sp_out  = SP_IDLE;
      end else if (!spmode) begin
         if (w_rise) begin
            w_shift  = {r_shift[6:0], w_sp};
            w_bitcnt = w_last ? 4'd0 : r_bitcnt + 4'd1;
            w_sdr    = w_last ? w_shift : w_sdr;
            w_irq    = w_last;
         end
      end else if (r_state == S_IDLE) begin
         if (r_pending) begin
            w_state   = S_SHIFT;
            w_shift   = r_sdr;
            w_pending = w_wr;
            w_bitcnt  = 4'd0;
         end
      end else if (tmra_ovf) begin
         if (r_cnt_out) begin
            w_cnt_out = 1'b0;
            w_sp_out  = r_shift[7];
            w_shift   = {r_shift[6:0], 1'b0};
         end else begin
            w_cnt_out = 1'b1;
            w_bitcnt  = r_bitcnt + 4'd1;
            if (w_last) begin
               w_irq = 1'b1;
               if (r_pending) begin
                  w_shift   = r_sdr;
                  w_pending = w_wr;
                  w_bitcnt  = 4'd0;
               end else w_state = S_IDLE;
            end
         end
      end
   end

   // State registers, advanced only on the 7 MHz enable
   always_ff @(posedge clk) begin
      if (clk7_en) begin
         if (reset) begin
            r_state    <= S_IDLE;
            r_sdr      <= 8'h00;
            r_shift    <= 8'h00;
            r_bitcnt   <= 4'd0;
            r_pending  <= 1'b0;
            r_cnt_out  <= CNT_IDLE;
            r_sp_out   <= SP_IDLE;
            r_irq      <= 1'b0;
            r_cnt_prev <= 1'b1;
            r_mode     <= 1'b0;
         end else begin
            r_state    <= w_state;
            r_sdr      <= w_sdr;
            r_shift    <= w_shift;
            r_bitcnt   <= w_bitcnt;
            r_pending  <= w_pending;
            r_cnt_out  <= w_cnt_out;
            r_sp_out   <= w_sp_out;
            r_irq      <= w_irq;
            r_cnt_prev <= w_cnt;
            r_mode     <= spmode;
         end
      end
   end
endmodule

// File: tb/tb_cia_serial.sv
// tb_cia_serial: directed self-checking bench with a bit-stream model of the serial port
module tb_cia_serial;
   logic       clk = 0, reset = 1, clk7_en = 1, wr = 0, sdr = 0, spmode = 0;
   logic [7:0] data_in = 0, data_out;
   logic       tmra_ovf = 0, sp_in = 1, cnt_in = 1, sp_out, cnt_out, irq;

   int nerr = 0, nchk = 0;
   int nbits = 0, irqs = 0, mode_age = 0, base;
   logic expq[$];
   logic [7:0] capq[$];
   logic [7:0] cap = 0, exp_in = 0, b;
   logic mon_en = 0, prev_cnt = 1, prev_irq = 0, prev_mode = 0;

   cia_serial dut (.clk(clk), .reset(reset), .clk7_en(clk7_en), .wr(wr), .sdr(sdr),
      .spmode(spmode), .data_in(data_in), .data_out(data_out), .tmra_ovf(tmra_ovf),
      .sp_in(sp_in), .cnt_in(cnt_in), .sp_out(sp_out), .cnt_out(cnt_out), .irq(irq));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic write(input logic [7:0] v);
      wr = 1; sdr = 1; data_in = v;
      tick();
      wr = 0; sdr = 0;
   endtask

   task automatic owrite(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) expq.push_back(v[i]);
      write(v);
   endtask

   task automatic readchk(input string nm, input logic [7:0] v);
      sdr = 1; #1;
      check(nm, data_out, v);
      sdr = 0;
   endtask

   task automatic ovf(input int n);
      repeat (n) begin tmra_ovf = 1; tick(); tmra_ovf = 0; tick(); end
   endtask

   task automatic ibit(input logic v);
      exp_in = {exp_in[6:0], v};
      cnt_in = 0; sp_in = v;
      tick(3);
      cnt_in = 1;
      tick(4);
   endtask

   // Output bits appear on sp_out at each cnt_out rise; irq only on every 8th rise
   always @(negedge clk) if (mon_en) begin
      mode_age = (spmode == prev_mode) ? mode_age + 1 : 0;
      prev_mode = spmode;
      if (irq) irqs++;
      if (irq && prev_irq) check("irq_single_cycle", 1, 0);
      if (spmode && !prev_cnt && cnt_out) begin
         if (expq.size() == 0) check("unexpected_bit", 1, 0);
         else check("sp_bit", sp_out, expq.pop_front());
         cap = {cap[6:0], sp_out};
         nbits++;
         check("irq_at_rise", irq, nbits % 8 == 0);
         if (nbits % 8 == 0) capq.push_back(cap);
      end else if (spmode) check("irq_off_rise", irq, 0);
      if (!spmode && mode_age >= 1) check("idle_pins", {cnt_out, sp_out}, 2'b11);
      prev_cnt = cnt_out;
      prev_irq = irq;
   end

   initial begin
      tick(3);
      reset = 0;
      readchk("reset_sdr", 8'h00);
      check("reset_pins", {cnt_out, sp_out, irq}, 3'b110);
      mon_en = 1;

      base = irqs;
      b = 8'hA5;
      for (int i = 7; i >= 0; i--) ibit(b[i]);
      readchk("in_a5_model", exp_in);
      readchk("in_a5_lit", 8'hA5);
      check("in_a5_irq", irqs - base, 1);

      write(8'h55);
      readchk("in_write", 8'h55);

      base = irqs;
      b = 8'hF0;
      for (int i = 7; i >= 1; i--) ibit(b[i]);
      exp_in = {exp_in[6:0], 1'b0};
      cnt_in = 0; sp_in = 0;
      tick(3);
      cnt_in = 1;
      tick(2);
      write(8'h55);
      tick(3);
      readchk("collide_sdr", exp_in);
      readchk("collide_lit", 8'hF0);
      check("collide_irq", irqs - base, 1);

      clk7_en = 0; wr = 1; sdr = 1; data_in = 8'h99; #1;
      check("rd_during_wr", data_out, 8'h00);
      tick(3);
      wr = 0; sdr = 0; #1;
      check("rd_unselected", data_out, 8'h00);
      clk7_en = 1;
      readchk("en_hold", 8'hF0);

      spmode = 1;
      tick(3);
      nbits = 0;
      base = irqs;
      owrite(8'h3C);
      tick(2);
      ovf(16);
      check("out_3c_irq", irqs - base, 1);
      check("out_3c_byte", capq.size() > 0 ? capq.pop_front() : 8'hxx, 8'h3C);
      check("out_3c_drained", expq.size(), 0);
      check("out_3c_idle", {cnt_out, sp_out}, 2'b10);
      ovf(3);
      check("out_idle_ovf", cnt_out, 1);

      base = irqs;
      owrite(8'h81);
      tick(2);
      ovf(3);
      owrite(8'h7E);
      ovf(29);
      check("b2b_irq", irqs - base, 2);
      check("b2b_byte0", capq.size() > 0 ? capq.pop_front() : 8'hxx, 8'h81);
      check("b2b_byte1", capq.size() > 0 ? capq.pop_front() : 8'hxx, 8'h7E);
      check("b2b_cnt_idle", cnt_out, 1);

      base = irqs;
      owrite(8'hC3);
      tick(2);
      ovf(5);
      check("abort_mid", cnt_out, 0);
      owrite(8'h11);
      spmode = 0;
      expq.delete();
      nbits = 0;
      tick(3);
      check("abort_pins", {cnt_out, sp_out}, 2'b11);
      check("abort_no_irq", irqs - base, 0);
      spmode = 1;
      tick(3);
      ovf(3);
      check("abort_cleared", cnt_out, 1);
      check("abort_no_irq2", irqs - base, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/cia_serial.md
# cia_serial

Serial data port (SDR) for the 8520 CIA model, clocked on the 7 MHz enable. It is the consumer of the CIA timer-A underflow. In output mode, each `tmra_ovf` underflow pulse paces one half-bit of a shifted byte on SP/CNT. In input mode, it shifts in bits clocked by an external CNT, for example the CIA-A keyboard line. It sits beside the timer blocks in the CIA top, which supplies the register select and the SPMODE bit (CRA bit 6).

## Interface
Parameters: none.

- `clk` input 1: system clock.
- `reset` input 1: reset, synchronous, active-high. Sampled only when `clk7_en`=1.
- `clk7_en` input 1: clock enable. No state changes when it is 0.
- `wr` input 1: bus write strobe.
- `sdr` input 1: SDR register select.
- `spmode` input 1: 1 = output mode, 0 = input mode.
- `data_in` input 8: bus write data.
- `data_out` output 8: SDR read data. Equals `sdr_reg` when `~wr & sdr`, else 8'h00.
- `tmra_ovf` input 1: timer-A underflow pulse. Acts as the shift pacer in output mode.
- `sp_in` input 1: serial data pin, asynchronous.
- `cnt_in` input 1: serial clock pin, asynchronous.
- `sp_out` output 1: serial data out. Valid in output mode; held at 1 otherwise.
- `cnt_out` output 1: serial clock out. Idles at 1.
- `irq` output 1: one enabled-cycle pulse at byte complete. Goes to the ICR SP bit.

## Operation
State: `sdr_reg[7:0]`, `shift[7:0]`, `bitcnt[3:0]` (range 0..8), `busy`, `pending`, `cnt_out`, `sp_out`, `irq`, and synchronizers for `sp_in`/`cnt_in`.

**Reset values**
- `sdr_reg`, `shift`, `bitcnt`: 0.
- `busy`, `pending`: 0.
- `cnt_out`, `sp_out`: 1.
- `irq`: 0.

**Bus access**
- A write (`sdr & wr`) always loads `sdr_reg` from `data_in`.
- In output mode the write also sets `pending`=1. A second write while `pending`=1 overwrites the buffered byte.

**Input mode (`spmode`=0)**
- Each synchronized CNT rising edge shifts MSB-first: `shift <= {shift[6:0], sp_sync}` and increments `bitcnt`.
- On the 8th edge:
  - `sdr_reg <= {shift[6:0], sp_sync}`
  - `irq <= 1`
  - `bitcnt <= 0`
- If a bus write and byte completion occur in the same cycle, the completed byte wins.

**Output mode (`spmode`=1): states**
- IDLE: `busy`=0.
- LOAD: IDLE with `pending`=1 → `shift <= sdr_reg`, `pending <= 0`, `busy <= 1`, `bitcnt <= 0`.
- SHIFT: `busy`=1, alternating on each `tmra_ovf`:
  - If `cnt_out`=1: `cnt_out <= 0`, `sp_out <= shift[7]`, `shift <= shift << 1`.
  - If `cnt_out`=0: `cnt_out <= 1`, `bitcnt++`.
- A byte takes 16 underflows.
- On the 8th CNT rising edge: `irq <= 1`.
  - If `pending`=1, reload `shift` from `sdr_reg` with no gap.
  - Otherwise go to IDLE; `sp_out` holds the last bit.
- A `tmra_ovf` that arrives in the LOAD cycle is ignored.

**Mode change**
- Any toggle of `spmode` aborts the transfer.
- It clears `busy`, `pending`, `bitcnt` and `shift` contents.
- It sets `cnt_out`=1 and `sp_out`=1.
- `irq` does not fire.

## Timing
- `irq` is a registered output, high for exactly one `clk7_en` cycle. It updates on the same edge as `sdr_reg` (input mode) or the 8th `cnt_out` rise (output mode).
- Input path:
  - 2-flop synchronizer, then edge detect against the previous synchronized value.
  - A pin change is acted on at the 3rd `clk7_en` edge after it is first sampled.
  - Pulses shorter than 2 enabled cycles are not guaranteed to register.
- Output path:
  - A write at enabled edge N sets `pending` at N and enters LOAD at N+1.
  - The first usable `tmra_ovf` is at N+2 or later.
- `data_out` is combinational from `sdr_reg`, `wr` and `sdr`.
- `reset` overrides everything, including a simultaneous write or edge.

## Structure
- Shared package `cia_pkg`:
  - `SDR_BITS` = 8
  - `CNT_IDLE` = 1'b1
  - `SP_IDLE` = 1'b1
- Sub-module `cia_sync2`: 2-flop enable-qualified synchronizer. Instantiated twice, for `sp_in` and `cnt_in`.

## Test plan
- Reset, then read SDR → `data_out`=8'h00, `cnt_out`=1, `sp_out`=1, `irq`=0.
- Input mode: clock in 0xA5 MSB-first on 8 slow CNT rises → after 8th edge plus sync latency, `sdr_reg`=0xA5 and a single-cycle `irq`; read returns 0xA5.
- Output mode: write 0x3C, pulse `tmra_ovf` 16 times → SP sequence 0,0,1,1,1,1,0,0, valid at each `cnt_out` rise; `irq` at the 16th underflow; then IDLE with `cnt_out`=1.
- Output back-to-back: write 0x81, write 0x7E during the first byte → 32 underflows produce 0x81 then 0x7E with no idle gap, and 2 `irq` pulses.
- Mode change mid-byte: after 5 underflows, drop `spmode` → `cnt_out`=1, `sp_out`=1, no `irq`; `busy` and `pending` cleared.
- Input collision: bus write 0x55 in the same cycle as the 8th CNT edge completing 0xF0 → `sdr_reg`=0xF0 and `irq` asserted.
